// File: rtl/control_pkg.sv
// control_pkg: shared types and constants for the control_unit sequencer.
//   - state_e    : sequencer states (WAIT only reachable with CONTROL_UNIT_STEP_EN)
//   - OPC_*      : opcode byte values
//   - ZSRC_*     : z-source field encodings, FLAG_* : bit indices into flags[0:5]
//   - ALU_*      : ALU operation codes
//   - decode()   : opcode -> {flags, alu_op, illegal}
package control_pkg;

  localparam int W       = 8;
  localparam int FLAGS_W = 6;
  localparam int OP_W    = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_HALT   = 3'd3,
    ST_WAIT   = 3'd4
  } state_e;

  localparam logic [W-1:0] OPC_NOP  = 8'h00;
  localparam logic [W-1:0] OPC_LDI  = 8'h01;
  localparam logic [W-1:0] OPC_MOV  = 8'h02;
  localparam logic [W-1:0] OPC_ADD  = 8'h03;
  localparam logic [W-1:0] OPC_ADDI = 8'h04;
  localparam logic [W-1:0] OPC_SUB  = 8'h05;
  localparam logic [W-1:0] OPC_SUBI = 8'h06;
  localparam logic [W-1:0] OPC_JMP  = 8'h07;
  localparam logic [W-1:0] OPC_JZ   = 8'h08;
  localparam logic [W-1:0] OPC_HALT = 8'h0F;

  localparam logic [1:0] ZSRC_NONE   = 2'd0;
  localparam logic [1:0] ZSRC_I2     = 2'd1;
  localparam logic [1:0] ZSRC_X      = 2'd2;
  localparam logic [1:0] ZSRC_RESULT = 2'd3;

  localparam int FLAG_ZSRC_HI = 0;
  localparam int FLAG_ZSRC_LO = 1;
  localparam int FLAG_B_SEL   = 2;
  localparam int FLAG_Z_WR    = 3;
  localparam int FLAG_X_RD    = 4;
  localparam int FLAG_Y_RD    = 5;

  localparam logic [OP_W-1:0] ALU_ADD    = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB    = 4'd1;
  localparam logic [OP_W-1:0] ALU_PASS_A = 4'd2;

  typedef struct packed {
    logic [0:FLAGS_W-1] flags;
    logic [OP_W-1:0]    alu_op;
    logic               illegal;
  } decode_t;

  function automatic logic [0:FLAGS_W-1] mk_flags(input logic [1:0] zsrc, input logic b_sel,
                                                  input logic z_wr, input logic x_rd,
                                                  input logic y_rd);
    logic [0:FLAGS_W-1] f;
    f[FLAG_ZSRC_HI] = zsrc[1];
    f[FLAG_ZSRC_LO] = zsrc[0];
    f[FLAG_B_SEL]   = b_sel;
    f[FLAG_Z_WR]    = z_wr;
    f[FLAG_X_RD]    = x_rd;
    f[FLAG_Y_RD]    = y_rd;
    return f;
  endfunction

  function automatic decode_t decode(input logic [W-1:0] opcode);
    decode_t d;
    d.flags   = '0;
    d.alu_op  = ALU_ADD;
    d.illegal = 1'b0;
    case (opcode)
      OPC_NOP, OPC_JMP, OPC_HALT: ;
      OPC_LDI:  d.flags = mk_flags(ZSRC_I2, 1'b0, 1'b1, 1'b0, 1'b0);
      OPC_MOV:  d.flags = mk_flags(ZSRC_X, 1'b0, 1'b1, 1'b1, 1'b0);
      OPC_ADD:  d.flags = mk_flags(ZSRC_RESULT, 1'b1, 1'b1, 1'b1, 1'b1);
      OPC_ADDI: d.flags = mk_flags(ZSRC_RESULT, 1'b0, 1'b1, 1'b1, 1'b0);
      OPC_SUB: begin
        d.flags  = mk_flags(ZSRC_RESULT, 1'b1, 1'b1, 1'b1, 1'b1);
        d.alu_op = ALU_SUB;
      end
      OPC_SUBI: begin
        d.flags  = mk_flags(ZSRC_RESULT, 1'b0, 1'b1, 1'b1, 1'b0);
        d.alu_op = ALU_SUB;
      end
      OPC_JZ: begin
        d.flags  = mk_flags(ZSRC_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
        d.alu_op = ALU_PASS_A;
      end
      default: d.illegal = 1'b1;  // undefined opcodes behave as NOP
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_unit_decoder.sv
// ctl_decoder: combinational opcode lookup.
// Ports:
//   opcode_i  in  [W-1:0]        instruction opcode byte
//   flags_o   out [0:FLAGS_W-1]  router flag vector for this opcode
//   alu_op_o  out [OP_W-1:0]     ALU operation select
//   illegal_o out                opcode is undefined
//   halt_o    out                opcode is HALT
module ctl_decoder
  import control_pkg::*;
(
  input  logic [W-1:0]       opcode_i,
  output logic [0:FLAGS_W-1] flags_o,
  output logic [OP_W-1:0]    alu_op_o,
  output logic               illegal_o,
  output logic               halt_o
);

  decode_t dec;

  assign dec       = decode(opcode_i);
  assign flags_o   = dec.flags;
  assign alu_op_o  = dec.alu_op;
  assign illegal_o = dec.illegal;
  assign halt_o    = (opcode_i == OPC_HALT);

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC sequencer with program counter.
// Optional macro CONTROL_UNIT_STEP_EN adds step_i and a WAIT state before
// every fetch (including the first one after reset).
// Ports:
//   clk_i, reset_i (async, active-high)
//   mem_addr_o/mem_req_o/mem_ack_i/mem_data_i : program memory read handshake
//   flags_o, alu_op_o : decoded controls, nonzero only during EXEC
//   i1_o, i2_o, i3_o  : latched instruction arguments
//   alu_zero_i        : ALU zero result, used by JZ in EXEC
//   pc_o, halted_o, illegal_o (sticky)
module control_unit
  import control_pkg::*;
(
  input  logic               clk_i,
  input  logic               reset_i,
`ifdef CONTROL_UNIT_STEP_EN
  input  logic               step_i,
`endif
  output logic [W-1:0]       mem_addr_o,
  output logic               mem_req_o,
  input  logic               mem_ack_i,
  input  logic [W-1:0]       mem_data_i,
  output logic [0:FLAGS_W-1] flags_o,
  output logic [W-1:0]       i1_o,
  output logic [W-1:0]       i2_o,
  output logic [W-1:0]       i3_o,
  output logic [OP_W-1:0]    alu_op_o,
  input  logic               alu_zero_i,
  output logic [W-1:0]       pc_o,
  output logic               halted_o,
  output logic               illegal_o
);

`ifdef CONTROL_UNIT_STEP_EN
  localparam state_e RESET_STATE = ST_WAIT;
`else
  localparam state_e RESET_STATE = ST_FETCH;
`endif

  state_e             state_q, state_d;
  logic [W-1:0]       pc_q, pc_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               req_q, req_d;
  logic [W-1:0]       addr_q, addr_d;
  logic [0:FLAGS_W-1] flags_q, flags_d;
  logic [OP_W-1:0]    alu_op_q, alu_op_d;
  logic               illegal_q, illegal_d;
  logic               capture;
  logic [W-1:0]       slot_q [4];  // 0=opcode, 1..3=i1..i3
  logic [W-1:0]       pc_next;
  logic               taken;

  logic [0:FLAGS_W-1] dec_flags;
  logic [OP_W-1:0]    dec_alu_op;
  logic               dec_illegal;
  logic               dec_halt;

  ctl_decoder u_dec (
    .opcode_i (slot_q[0]),
    .flags_o  (dec_flags),
    .alu_op_o (dec_alu_op),
    .illegal_o(dec_illegal),
    .halt_o   (dec_halt)
  );

  // One capture register per instruction byte, written when its ack arrives.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          slot_q[gi] <= '0;
        end else if (capture && (cnt_q == 2'(gi))) begin
          slot_q[gi] <= mem_data_i;
        end
      end
    end
  endgenerate

  assign taken   = (slot_q[0] == OPC_JMP) || ((slot_q[0] == OPC_JZ) && alu_zero_i);
  assign pc_next = taken ? slot_q[1] : pc_q + W'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    addr_d    = addr_q;
    flags_d   = '0;
    alu_op_d  = '0;
    illegal_d = illegal_q;
    capture   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (!req_q) begin
          // First fetch after reset: raise the request this cycle.
          req_d  = 1'b1;
          addr_d = pc_q + W'(cnt_q);
        end else if (mem_ack_i) begin
          capture = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            req_d   = 1'b0;
            state_d = ST_DECODE;
          end else begin
            addr_d = pc_q + W'(cnt_q) + W'(1);  // wraps past 0xFF naturally
          end
        end
      end
      ST_DECODE: begin
        illegal_d = illegal_q | dec_illegal;
        if (dec_halt) begin
          state_d = ST_HALT;
        end else begin
          flags_d  = dec_flags;
          alu_op_d = dec_alu_op;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_d = pc_next;
`ifdef CONTROL_UNIT_STEP_EN
        state_d = ST_WAIT;
`else
        // Issue the next request straight away so the fetch starts next cycle.
        state_d = ST_FETCH;
        req_d   = 1'b1;
        addr_d  = pc_next;
`endif
      end
`ifdef CONTROL_UNIT_STEP_EN
      ST_WAIT: begin
        if (step_i) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end
`endif
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= RESET_STATE;
      pc_q      <= '0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      flags_q   <= '0;
      alu_op_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      flags_q   <= flags_d;
      alu_op_q  <= alu_op_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_addr_o = addr_q;
  assign mem_req_o  = req_q;
  assign flags_o    = flags_q;
  assign alu_op_o   = alu_op_q;
  assign i1_o       = slot_q[1];
  assign i2_o       = slot_q[2];
  assign i3_o       = slot_q[3];
  assign pc_o       = pc_q;
  assign halted_o   = (state_q == ST_HALT);
  assign illegal_o  = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: memory model answers fetches, expected
// per-instruction results are queued at load time and popped after EXEC.
module tb_control_unit;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [7:0]  mem_addr_o;
  logic        mem_req_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_data_i = 8'h00;
  logic [0:5]  flags_o;
  logic [7:0]  i1_o, i2_o, i3_o;
  logic [3:0]  alu_op_o;
  logic        alu_zero_i = 1'b0;
  logic [7:0]  pc_o;
  logic        halted_o;
  logic        illegal_o;
`ifdef CONTROL_UNIT_STEP_EN
  logic        step_i = 1'b1;
`endif

  always #5 clk = ~clk;

  control_unit dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
`ifdef CONTROL_UNIT_STEP_EN
    .step_i    (step_i),
`endif
    .mem_addr_o(mem_addr_o),
    .mem_req_o (mem_req_o),
    .mem_ack_i (mem_ack_i),
    .mem_data_i(mem_data_i),
    .flags_o   (flags_o),
    .i1_o      (i1_o),
    .i2_o      (i2_o),
    .i3_o      (i3_o),
    .alu_op_o  (alu_op_o),
    .alu_zero_i(alu_zero_i),
    .pc_o      (pc_o),
    .halted_o  (halted_o),
    .illegal_o (illegal_o)
  );

  typedef struct packed {
    logic [0:5] flags;
    logic [3:0] alu_op;
    logic [7:0] i1, i2, pc_next, addr0;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    logic       ok, gap_drop;
    logic [0:5] dec_flags;
    logic       dec_req;
    logic [0:5] ex_flags;
    logic [3:0] ex_alu;
    logic [7:0] ex_i1, ex_i2;
    logic       ex_halted, ex_illegal;
    logic [0:5] post_flags;
    logic [7:0] post_pc;
  } obs_t;

  logic [7:0] mem [256];
  exp_t       exp_q[$];
  logic [7:0] addr_seen[$];
  int         tests = 0;
  int         fails = 0;

  task automatic load(input logic [7:0] a, input logic [7:0] b0, b1, b2, b3);
    logic [7:0] idx;
    idx = a;      mem[idx] = b0;
    idx = a + 1;  mem[idx] = b1;
    idx = a + 2;  mem[idx] = b2;
    idx = a + 3;  mem[idx] = b3;
  endtask

  // Serves one 4-byte fetch (gap idle cycles before each ack), then samples
  // the DECODE, EXEC and following cycle. Called and returns on a negedge.
  task automatic run_instr(input int gap, input logic zero, output obs_t o);
    o = '0;
    o.ok = 1'b1;
    addr_seen.delete();
    alu_zero_i = zero;
    for (int b = 0; b < 4; b++) begin
      int n = 0;
      while (mem_req_o !== 1'b1) begin
        mem_ack_i = 1'b0;
        @(negedge clk);
        n++;
        if (n > 50) begin
          o.ok = 1'b0;
          return;
        end
      end
      for (int g = 0; g < gap; g++) begin
        mem_ack_i = 1'b0;
        @(negedge clk);
        if (mem_req_o !== 1'b1) o.gap_drop = 1'b1;
      end
      mem_ack_i  = 1'b1;
      mem_data_i = mem[mem_addr_o];
      addr_seen.push_back(mem_addr_o);
      @(negedge clk);
    end
    mem_ack_i = 1'b0;
    o.dec_flags = flags_o;
    o.dec_req   = mem_req_o;
    @(negedge clk);
    o.ex_flags   = flags_o;
    o.ex_alu     = alu_op_o;
    o.ex_i1      = i1_o;
    o.ex_i2      = i2_o;
    o.ex_halted  = halted_o;
    o.ex_illegal = illegal_o;
    @(negedge clk);
    o.post_flags = flags_o;
    o.post_pc    = pc_o;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    @(negedge clk);
    tests++;
    if ({pc_o, mem_req_o, flags_o, alu_op_o, halted_o, illegal_o, i1_o, i2_o, i3_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs pc=%h req=%b flags=%b op=%h halt=%b ill=%b i=%h/%h/%h exp all zero",
               pc_o, mem_req_o, flags_o, alu_op_o, halted_o, illegal_o, i1_o, i2_o, i3_o);
    end
    reset_i = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_ldi;
    obs_t o; exp_t e;
    load(8'h00, 8'h01, 8'h03, 8'h5A, 8'h00);
    exp_q.push_back('{flags: 6'b010100, alu_op: 4'd0, i1: 8'h03, i2: 8'h5A, pc_next: 8'h04, addr0: 8'h00, illegal: 1'b0});
    run_instr(0, 1'b0, o);
    e = exp_q.pop_front();
    tests++;
    if (!o.ok || addr_seen.size() != 4 || addr_seen[0] !== 8'h00 || addr_seen[3] !== 8'h03) begin
      fails++; $display("FAIL ldi_fetch ok=%b n=%0d exp 4 reqs at 00..03", o.ok, addr_seen.size());
    end
    tests++;
    if (o.dec_flags !== 6'b0 || o.dec_req !== 1'b0 || o.post_flags !== 6'b0) begin
      fails++; $display("FAIL ldi_flags_outside_exec dec=%b req=%b post=%b exp 0", o.dec_flags, o.dec_req, o.post_flags);
    end
    tests++;
    if (o.ex_flags !== e.flags || o.ex_i1 !== e.i1 || o.ex_i2 !== e.i2 || o.post_pc !== e.pc_next) begin
      fails++; $display("FAIL ldi_exec flags=%b i1=%h i2=%h pc=%h exp %b %h %h %h",
                        o.ex_flags, o.ex_i1, o.ex_i2, o.post_pc, e.flags, e.i1, e.i2, e.pc_next);
    end
    $display("[TB] ldi pc=%h flags=%b", o.post_pc, o.ex_flags);
  endtask

  task automatic test_add_gaps;
    obs_t o; exp_t e;
    load(8'h04, 8'h03, 8'h03, 8'h01, 8'h02);
    exp_q.push_back('{flags: 6'b111111, alu_op: 4'd0, i1: 8'h03, i2: 8'h01, pc_next: 8'h08, addr0: 8'h04, illegal: 1'b0});
    run_instr(1, 1'b0, o);
    e = exp_q.pop_front();
    tests++;
    if (!o.ok || o.gap_drop || addr_seen.size() != 4 || addr_seen[0] !== e.addr0 || addr_seen[3] !== 8'h07) begin
      fails++; $display("FAIL add_gap_fetch ok=%b drop=%b exp req held, addrs 04..07", o.ok, o.gap_drop);
    end
    tests++;
    if (o.ex_flags !== e.flags || o.ex_alu !== e.alu_op || o.dec_flags !== 6'b0 || o.post_flags !== 6'b0
        || o.post_pc !== e.pc_next) begin
      fails++; $display("FAIL add_exec flags=%b op=%h pc=%h exp %b %h %h", o.ex_flags, o.ex_alu, o.post_pc,
                        e.flags, e.alu_op, e.pc_next);
    end
    $display("[TB] add pc=%h flags=%b", o.post_pc, o.ex_flags);
  endtask

  task automatic test_jz;
    obs_t o; exp_t e;
    load(8'h08, 8'h08, 8'h10, 8'h05, 8'h00);
    exp_q.push_back('{flags: 6'b000010, alu_op: 4'd2, i1: 8'h10, i2: 8'h05, pc_next: 8'h10, addr0: 8'h08, illegal: 1'b0});
    load(8'h10, 8'h08, 8'h20, 8'h05, 8'h00);
    exp_q.push_back('{flags: 6'b000010, alu_op: 4'd2, i1: 8'h20, i2: 8'h05, pc_next: 8'h14, addr0: 8'h10, illegal: 1'b0});
    for (int k = 0; k < 2; k++) begin
      run_instr(0, (k == 0), o);
      e = exp_q.pop_front();
      tests++;
      if (!o.ok || o.ex_flags !== e.flags || o.ex_alu !== e.alu_op || o.post_pc !== e.pc_next) begin
        fails++; $display("FAIL jz_%0d flags=%b op=%h pc=%h exp %b %h %h", k, o.ex_flags, o.ex_alu,
                          o.post_pc, e.flags, e.alu_op, e.pc_next);
      end
      $display("[TB] jz zero=%0d pc=%h", (k == 0), o.post_pc);
    end
  endtask

  task automatic test_wrap;
    obs_t o; exp_t e;
    load(8'h14, 8'h07, 8'hFC, 8'h00, 8'h00);
    exp_q.push_back('{flags: 6'b0, alu_op: 4'd0, i1: 8'hFC, i2: 8'h00, pc_next: 8'hFC, addr0: 8'h14, illegal: 1'b0});
    load(8'hFC, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_q.push_back('{flags: 6'b0, alu_op: 4'd0, i1: 8'h00, i2: 8'h00, pc_next: 8'h00, addr0: 8'hFC, illegal: 1'b0});
    for (int k = 0; k < 2; k++) begin
      run_instr(0, 1'b1, o);
      e = exp_q.pop_front();
      tests++;
      if (!o.ok || addr_seen[0] !== e.addr0 || o.ex_flags !== e.flags || o.post_pc !== e.pc_next) begin
        fails++; $display("FAIL wrap_%0d addr0=%h flags=%b pc=%h exp %h %b %h", k, addr_seen[0],
                          o.ex_flags, o.post_pc, e.addr0, e.flags, e.pc_next);
      end
      $display("[TB] jmp/nop pc=%h", o.post_pc);
    end
  endtask

  task automatic test_straddle;
    obs_t o; exp_t e;
    load(8'h00, 8'h07, 8'hFE, 8'h00, 8'h00);
    exp_q.push_back('{flags: 6'b0, alu_op: 4'd0, i1: 8'hFE, i2: 8'h00, pc_next: 8'hFE, addr0: 8'h00, illegal: 1'b0});
    // MOV at FE: bytes FE,FF then 00,01 which hold 07,FE from the JMP above
    mem[8'hFE] = 8'h02;
    mem[8'hFF] = 8'h07;
    exp_q.push_back('{flags: 6'b100110, alu_op: 4'd0, i1: 8'h07, i2: 8'h07, pc_next: 8'h02, addr0: 8'hFE, illegal: 1'b0});
    for (int k = 0; k < 2; k++) begin
      run_instr(0, 1'b0, o);
      e = exp_q.pop_front();
      tests++;
      if (!o.ok || addr_seen[0] !== e.addr0 || o.ex_flags !== e.flags || o.ex_i1 !== e.i1
          || o.ex_i2 !== e.i2 || o.post_pc !== e.pc_next) begin
        fails++; $display("FAIL straddle_%0d flags=%b i1=%h i2=%h pc=%h exp %b %h %h %h", k, o.ex_flags,
                          o.ex_i1, o.ex_i2, o.post_pc, e.flags, e.i1, e.i2, e.pc_next);
      end
    end
    tests++;
    if (addr_seen.size() != 4 || addr_seen[1] !== 8'hFF || addr_seen[2] !== 8'h00 || addr_seen[3] !== 8'h01) begin
      fails++; $display("FAIL straddle_addrs n=%0d exp FE,FF,00,01", addr_seen.size());
    end
    $display("[TB] straddle pc=%h flags=%b", o.post_pc, o.ex_flags);
  endtask

  task automatic test_illegal_halt;
    obs_t o; exp_t e;
    int req_seen = 0;
    load(8'h02, 8'h0C, 8'h11, 8'h22, 8'h33);
    exp_q.push_back('{flags: 6'b0, alu_op: 4'd0, i1: 8'h11, i2: 8'h22, pc_next: 8'h06, addr0: 8'h02, illegal: 1'b1});
    load(8'h06, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_q.push_back('{flags: 6'b0, alu_op: 4'd0, i1: 8'h00, i2: 8'h00, pc_next: 8'h0A, addr0: 8'h06, illegal: 1'b1});
    for (int k = 0; k < 2; k++) begin
      run_instr(0, 1'b0, o);
      e = exp_q.pop_front();
      tests++;
      if (!o.ok || o.ex_flags !== e.flags || o.ex_illegal !== e.illegal || illegal_o !== 1'b1
          || o.post_pc !== e.pc_next) begin
        fails++; $display("FAIL illegal_%0d flags=%b ill=%b pc=%h exp %b %b %h", k, o.ex_flags,
                          o.ex_illegal, o.post_pc, e.flags, e.illegal, e.pc_next);
      end
    end
    load(8'h0A, 8'h0F, 8'h00, 8'h00, 8'h00);
    run_instr(0, 1'b0, o);
    tests++;
    if (!o.ok || o.ex_halted !== 1'b1 || o.ex_flags !== 6'b0 || pc_o !== 8'h0A) begin
      fails++; $display("FAIL halt_enter halted=%b flags=%b pc=%h exp 1 000000 0a", o.ex_halted, o.ex_flags, pc_o);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req_o !== 1'b0 || halted_o !== 1'b1) req_seen++;
    end
    tests++;
    if (req_seen != 0) begin
      fails++; $display("FAIL halt_hold bad_cycles=%0d exp 0", req_seen);
    end
    $display("[TB] halt halted=%b", halted_o);
  endtask

  task automatic test_reset_mid_fetch;
    obs_t o; exp_t e;
    int n = 0;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    load(8'h00, 8'h01, 8'h07, 8'h33, 8'h00);
    exp_q.push_back('{flags: 6'b010100, alu_op: 4'd0, i1: 8'h07, i2: 8'h33, pc_next: 8'h04, addr0: 8'h00, illegal: 1'b0});
    for (int b = 0; b < 2; b++) begin
      while (mem_req_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      mem_ack_i  = 1'b1;
      mem_data_i = mem[mem_addr_o];
      @(negedge clk);
    end
    mem_data_i = 8'hEE;  // ack stays high through reset: must be ignored
    #2 reset_i = 1'b1;
    #1;
    tests++;
    if ({mem_req_o, pc_o, i1_o, flags_o, halted_o} !== '0) begin
      fails++; $display("FAIL reset_mid req=%b pc=%h i1=%h flags=%b exp all zero", mem_req_o, pc_o, i1_o, flags_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    run_instr(0, 1'b0, o);
    e = exp_q.pop_front();
    tests++;
    if (!o.ok || addr_seen[0] !== e.addr0 || o.ex_flags !== e.flags || o.ex_i1 !== e.i1
        || o.ex_i2 !== e.i2 || o.post_pc !== e.pc_next) begin
      fails++; $display("FAIL refetch flags=%b i1=%h i2=%h pc=%h exp %b %h %h %h", o.ex_flags, o.ex_i1,
                        o.ex_i2, o.post_pc, e.flags, e.i1, e.i2, e.pc_next);
    end
    $display("[TB] refetch after reset pc=%h i1=%h", o.post_pc, o.ex_i1);
  endtask

`ifdef CONTROL_UNIT_STEP_EN
  task automatic test_step;
    obs_t o;
    int bad = 0;
    step_i  = 1'b0;
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (mem_req_o !== 1'b0) bad++; end
    step_i = 1'b1;
    @(negedge clk);
    step_i = 1'b0;
    run_instr(0, 1'b0, o);
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (mem_req_o !== 1'b0) bad++; end
    tests++;
    if (!o.ok || bad != 0 || pc_o !== 8'h04) begin
      fails++; $display("FAIL step ok=%b bad=%0d pc=%h exp 1 0 04", o.ok, bad, pc_o);
    end
    step_i = 1'b1;
    $display("[TB] step pc=%h", pc_o);
  endtask
`endif

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    test_reset();
    test_ldi();
    test_add_gaps();
    test_jz();
    test_wrap();
    test_straddle();
    test_illegal_halt();
    test_reset_mid_fetch();
`ifdef CONTROL_UNIT_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
